// File: rtl/vslc_pkg.sv
// VSLC sequencer shared types: scan FSM states and reserved opcodes.
// Imported by the sequencer top and its program RAM.
package vslc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SNAP,
    RUN,
    END
  } seq_state_t;

  localparam logic [7:0] VSLC_HALT = 8'hFF;
  localparam logic [7:0] VSLC_NOP  = 8'h00;

endpackage

// File: rtl/vslc_instr_sequencer_if.sv
// Program byte stream and instruction channel between
// the sequencer (master) and the loader/executor (slave).
interface vslc_instr_sequencer_if;

  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic [7:0] instr;
  logic       instr_ready;

  modport master (
    input  load_valid,
    input  load_data,
    output load_ready,
    output instr,
    output instr_ready
  );

  modport slave (
    output load_valid,
    output load_data,
    input  load_ready,
    input  instr,
    input  instr_ready
  );

endinterface

// File: rtl/vslc_prog_ram.sv
// Ladder program store: DEPTH x 8, one write port,
// one registered read port (read latency 1).
module vslc_prog_ram
  import vslc_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vslc_instr_sequencer.sv
// Replays the loaded ladder program as a scan loop.
// Optional: VSLC_SEQ_HALT_OPCODE_EN ends a scan at 8'hFF.
module vslc_instr_sequencer
  import vslc_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic          run_en,
  input  logic [7:0]    ui_in,
  output logic [7:0]    ui_in_o,
  output logic [7:0]    ui_in_prev,
  output logic          scan_done,
  output logic [AW:0]   prog_len,
  vslc_instr_sequencer_if.master bus
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  seq_state_t  state_q, state_d;
  logic [AW:0] pc_q, pc_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] prog_len_q, prog_len_d;
  logic [7:0]  ui_o_q, ui_o_d;
  logic [7:0]  ui_prev_q, ui_prev_d;
  logic        rd_vld_q, rd_vld_d;

  logic [7:0]  rd_data;
  logic        xfer;
  logic        rd_en;
  logic        halt_hit;
  logic        last_hit;

  assign bus.load_ready = (state_q == LOAD)
                       && (wr_ptr_q != FULL);
  assign xfer = bus.load_valid && bus.load_ready;

`ifdef VSLC_SEQ_HALT_OPCODE_EN
  assign halt_hit = rd_vld_q && (rd_data == VSLC_HALT);
`else
  assign halt_hit = 1'b0;
`endif

  // pc counts reads issued; the scan ends once the
  // final read has come back out of the RAM
  assign rd_en = (state_q == RUN)
              && (pc_q != prog_len_q)
              && !halt_hit;
  assign last_hit = rd_vld_q && (pc_q == prog_len_q);

  vslc_prog_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (xfer),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (bus.load_data),
    .re    (rd_en),
    .raddr (pc_q[AW-1:0]),
    .rdata (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    ui_o_d     = ui_o_q;
    ui_prev_d  = ui_prev_q;
    rd_vld_d   = rd_en;
    unique case (state_q)
      IDLE: begin
        if (load_en) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
          ui_o_d     = '0;
          ui_prev_d  = '0;
        end else if (run_en && (prog_len_q != '0)) begin
          state_d = SNAP;
        end
      end
      LOAD: begin
        if (xfer) begin
          wr_ptr_d   = wr_ptr_q + 1'b1;
          prog_len_d = wr_ptr_q + 1'b1;
        end
        if (!load_en) begin
          state_d = IDLE;
        end
      end
      SNAP: begin
        ui_prev_d = ui_o_q;
        ui_o_d    = ui_in;
        pc_d      = '0;
        state_d   = RUN;
      end
      RUN: begin
        if (rd_en) begin
          pc_d = pc_q + 1'b1;
        end
        if (halt_hit || last_hit) begin
          state_d = END;
        end
      end
      END: begin
        if (load_en) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
          ui_o_d     = '0;
          ui_prev_d  = '0;
        end else if (run_en && (prog_len_q != '0)) begin
          state_d = SNAP;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      ui_o_q     <= '0;
      ui_prev_q  <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      ui_o_q     <= ui_o_d;
      ui_prev_q  <= ui_prev_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  // a held-back halt byte never reaches the executor
  assign bus.instr_ready = rd_vld_q && !halt_hit;
  assign bus.instr = bus.instr_ready ? rd_data
                                     : VSLC_NOP;

  assign ui_in_o    = ui_o_q;
  assign ui_in_prev = ui_prev_q;
  assign scan_done  = (state_q == END);
  assign prog_len   = prog_len_q;

endmodule

// File: tb/tb_vslc_instr_sequencer.sv
// Scoreboard bench for vslc_instr_sequencer: expected
// instructions are queued per scan and popped on issue.
module tb_vslc_instr_sequencer;
  import vslc_pkg::*;

  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_en = 1'b0;
  logic          run_en = 1'b0;
  logic [7:0]    ui_in = 8'h00;
  logic [7:0]    ui_in_o;
  logic [7:0]    ui_in_prev;
  logic          scan_done;
  logic [AW:0]   prog_len;

  vslc_instr_sequencer_if bus ();

  vslc_instr_sequencer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .run_en     (run_en),
    .ui_in      (ui_in),
    .ui_in_o    (ui_in_o),
    .ui_in_prev (ui_in_prev),
    .scan_done  (scan_done),
    .prog_len   (prog_len),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic [7:0] uo;
    logic [7:0] up;
  } exp_t;

  exp_t       sbq[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [7:0] prog [0:63];
  logic [7:0] uiv  [0:7];
  int         plen = 0;
  logic [7:0] m_o = 8'h00;
  logic [7:0] m_p = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.instr_ready) begin
        if (sbq.size() == 0) begin
          check("unexp_instr", sbq.size(), 1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("instr", bus.instr, e.b);
          check("ui_in_o", ui_in_o, e.uo);
          check("ui_in_prev", ui_in_prev, e.up);
        end
      end else begin
        check("instr_idle", bus.instr, 8'h00);
      end
    end
  end

  // model one scan: snapshot shift, then expected bytes
  function automatic int push_scan(input logic [7:0] u);
    m_p = m_o;
    m_o = u;
    for (int i = 0; i < plen; i++) begin
`ifdef VSLC_SEQ_HALT_OPCODE_EN
      if (prog[i] == 8'hFF) return i + 4;
`endif
      sbq.push_back('{prog[i], m_o, m_p});
    end
    return plen + 3;
  endfunction

  task automatic load_prog(input int n);
    int i;
    int t;
    int exp_acc;
    exp_acc = (n > DEPTH) ? DEPTH : n;
    load_en = 1'b1;
    run_en  = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus.load_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("load_entry", bus.load_ready, 1);
    check("len_clr", prog_len, 0);
    i = 0;
    t = 0;
    while (i < n && t < n + 6) begin
      bus.load_valid = 1'b1;
      bus.load_data  = prog[i];
      if (bus.load_ready) i++;
      @(negedge clk);
      t++;
    end
    check("accepted", i, exp_acc);
    if (n > DEPTH) check("full_ready", bus.load_ready, 0);
    bus.load_valid = 1'b0;
    load_en = 1'b0;
    @(negedge clk);
    check("prog_len", prog_len, exp_acc);
    plen = exp_acc;
    m_o = 8'h00;
    m_p = 8'h00;
  endtask

  task automatic run_scans(input int k, input bit junk);
    int t;
    int last;
    int per;
    ui_in = uiv[0];
    per = push_scan(uiv[0]);
    run_en = 1'b1;
    last = -1;
    for (int s = 0; s < k; s++) begin
      t = 0;
      @(negedge clk);
      while (!scan_done && t < DEPTH * 4) begin
        if (junk && bus.instr_ready) ui_in = 8'hE7;
        @(negedge clk);
        t++;
      end
      check("scan_done_seen", scan_done, 1);
      check("sb_drain", sbq.size(), 0);
      if (last >= 0) check("period", cyc - last, per);
      last = cyc;
      if (s + 1 < k) begin
        ui_in = uiv[s+1];
        per = push_scan(uiv[s+1]);
      end else begin
        run_en = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int t;
    int cnt;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_instr", bus.instr, 0);
    check("rst_instr_ready", bus.instr_ready, 0);
    check("rst_load_ready", bus.load_ready, 0);
    check("rst_ui_in_o", ui_in_o, 0);
    check("rst_ui_in_prev", ui_in_prev, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_prog_len", prog_len, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // empty program must never start a scan
    run_en = 1'b1;
    repeat (6) @(negedge clk);
    check("empty_no_scan", scan_done, 0);
    run_en = 1'b0;

    prog[0] = 8'h01; prog[1] = 8'h42; prog[2] = 8'h9C;
    load_prog(3);
    uiv[0] = 8'h00; uiv[1] = 8'h00; uiv[2] = 8'h00;
    run_scans(3, 1'b0);

    uiv[0] = 8'h05; uiv[1] = 8'h0A; uiv[2] = 8'h33;
    run_scans(3, 1'b1);

    for (int i = 0; i < DEPTH + 2; i++) begin
      prog[i] = 8'((i * 5 + 1) & 8'hFF);
    end
    load_prog(DEPTH + 2);
    uiv[0] = 8'h11; uiv[1] = 8'h22;
    run_scans(2, 1'b0);

    // load request mid-scan: scan finishes, then LOAD
    prog[0] = 8'h10; prog[1] = 8'h20;
    prog[2] = 8'h30; prog[3] = 8'h40;
    load_prog(4);
    ui_in = 8'h5A;
    void'(push_scan(8'h5A));
    run_en = 1'b1;
    cnt = 0;
    t = 0;
    while (cnt < 2 && t < 50) begin
      @(negedge clk);
      if (bus.instr_ready) cnt++;
      t++;
    end
    check("second_instr", cnt, 2);
    load_en = 1'b1;
    t = 0;
    while (!scan_done && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ld_scan_done", scan_done, 1);
    check("ld_sb_drain", sbq.size(), 0);
    @(negedge clk);
    check("ld_after_end", bus.load_ready, 1);
    check("ld_len_clr", prog_len, 0);

    prog[0] = 8'h01; prog[1] = 8'hFF; prog[2] = 8'h02;
    load_prog(3);
    uiv[0] = 8'h77; uiv[1] = 8'h88;
    run_scans(2, 1'b0);

    // reset in the middle of a scan
    ui_in = 8'h99;
    void'(push_scan(8'h99));
    run_en = 1'b1;
    cnt = 0;
    t = 0;
    while (cnt < 1 && t < 50) begin
      @(negedge clk);
      if (bus.instr_ready) cnt++;
      t++;
    end
    check("rst_first_instr", cnt, 1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    m_o = 8'h00;
    m_p = 8'h00;
    mon_en = 1'b1;
    check("mid_rst_len", prog_len, 0);
    check("mid_rst_ready", bus.instr_ready, 0);
    repeat (8) @(negedge clk);
    check("mid_rst_ui_o", ui_in_o, 0);
    check("mid_rst_done", scan_done, 0);
    run_en = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
